icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
// Sequences instruction-cache line refills from the single-port instruction memory
// (blk_mem_gen_0) into ICACHE on a fetch miss. Sits in the FETCH stage, between the
// PC/ICACHE lookup and the instruction memory port. Issues critical-word-first,
// wrap-around word reads, writes each returned word into ICACHE, forwards the
// critical word to IF/ID early and holds the PC via stall_o until the line is valid.
// PARAMETERS
// ADDR_W    20  byte-address width of instruction memory port
// DATA_W    32  instruction word width
// LINE_W    16  words per cache line (power of 2; offset width OFF_W = log2(LINE_W))
// TAG_W     4   tag width; tag = miss_addr_i[2+OFF_W+TAG_W-1 : 2+OFF_W]
// MEM_LAT   1   memory read latency in cycles, >=1
// PORTS
// CLK              in   1        clock, rising edge
// RSTn             in   1        reset, asynchronous, active-low
// EN               in   1        global enable; low suspends new memory issues only
// load_ctrl_i      in   1        TB program loader owns memory; aborts refill
// miss_i           in   1        fetch lookup missed (ICACHE match==0, valid fetch)
// miss_addr_i      in   ADDR_W   byte PC of missing fetch
// flush_i          in   1        PC redirected (branch/jump); abandon refill
// mem_en_o         out  1        memory chip enable (read)
// mem_addr_o       out  ADDR_W   memory byte address
// mem_rdata_i      in   DATA_W   memory read data, MEM_LAT cycles after issue
// cache_inval_o    out  1        1-cycle pulse: clear valid of line being refilled
// cache_we_n_o     out  1        ICACHE word write enable, active-low
// cache_offset_o   out  OFF_W    ICACHE word offset for write
// cache_tag_o      out  TAG_W    tag of line being refilled
// cache_wdata_o    out  DATA_W   word written into ICACHE
// cache_valid_o    out  1        1-cycle pulse: set line valid with cache_tag_o
// crit_valid_o     out  1        1-cycle pulse: critical word available
// crit_data_o      out  DATA_W   critical instruction word
// stall_o          out  1        hold PC / IF-ID; = (state != IDLE)
// BEHAVIOUR
// - Reset: state=IDLE, counters/pipe cleared; all outputs 0 except cache_we_n_o=1.
// - States: IDLE, FILL, DRAIN, DONE.
// - IDLE: miss_i & !flush_i & !load_ctrl_i at edge t -> FILL at t+1; latch
//   base=miss_addr_i & ~(4*LINE_W-1), crit=miss_addr_i[2+:OFF_W], tag. flush_i wins
//   over simultaneous miss_i (miss ignored).
// - FILL: cycle t+1 pulses cache_inval_o. Each cycle with EN=1 and issue_cnt<LINE_W:
//   mem_en_o=1, mem_addr_o=base+4*((crit+issue_cnt) mod LINE_W), issue_cnt++.
//   EN=0: mem_en_o=0, issue_cnt held; in-flight returns still processed.
// - Returns: MEM_LAT-deep valid/offset shift pipe; when valid exits, cache_we_n_o=0,
//   cache_offset_o=carried offset, cache_wdata_o=mem_rdata_i, ret_cnt++.
//   First return (offset==crit): crit_valid_o=1, crit_data_o=mem_rdata_i.
// - ret_cnt==LINE_W -> DONE: cache_valid_o=1 for one cycle -> IDLE.
//   Nominal: first issue t+1, crit word t+1+MEM_LAT, valid pulse t+LINE_W+MEM_LAT+1.
// - flush_i in FILL -> DRAIN: no issues, returns discarded (cache_we_n_o=1, no
//   crit_valid_o); pipe empty -> IDLE; no cache_valid_o (line stays invalid).
// - flush_i in DRAIN/DONE: ignored. miss_i outside IDLE: ignored.
// - load_ctrl_i high in any state -> IDLE next edge, pipe cleared, mem_en_o=0
//   same cycle, no cache writes/pulses.
// - Offset wrap: (crit+k) mod LINE_W, OFF_W-bit natural overflow; base never changes.
// - RSTn low mid-refill: async return to reset values; line left invalidated.
// TESTING
// T1 miss_addr=0x00048 (crit=2), MEM_LAT=1, EN=1 -> addrs 0x48..0x7C,0x40,0x44;
//    crit_valid at t+2 with word@0x48; cache_valid at t+18; stall_o t+1..t+18.
// T2 miss_addr=0x0007C (crit=15) -> offsets 15,0,1..14; base 0x40; tag=1.
// T3 flush_i at 5th FILL cycle -> issues stop, MEM_LAT returns discarded,
//    no cache_valid pulse, IDLE after drain.
// T4 EN low 3 cycles mid-FILL -> mem_en_o=0 those cycles, sequence resumes
//    unbroken, cache_valid 3 cycles late, all 16 words correct.
// T5 load_ctrl_i mid-FILL, then miss at 0x00100 -> immediate abort; fresh refill correct.
// T6 miss_i & flush_i same IDLE cycle -> stays IDLE; RSTn low in FILL -> outputs reset async.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - critical-word-first instruction cache line refill sequencer
//
// Purpose: on a fetch miss, invalidates the target line, reads the whole line
// from instruction memory starting at the missing word (wrapping within the
// line), writes each returned word into the cache, forwards the critical word
// early and holds the PC via stall_o until the line is marked valid.
//
// Ports:
//   CLK, RSTn                 clock (rising edge), async active-low reset
//   EN                        low suspends new memory issues only
//   load_ctrl_i               program loader owns memory; aborts any refill
//   miss_i, miss_addr_i       fetch miss request and its byte address
//   flush_i                   PC redirect; abandons a refill in progress
//   mem_en_o, mem_addr_o      memory read issue
//   mem_rdata_i               memory read data, MEM_LAT cycles after issue
//   cache_inval_o             pulse: clear valid of the line being refilled
//   cache_we_n_o              cache word write enable (active-low)
//   cache_offset_o/wdata_o    cache word write offset and data
//   cache_tag_o               tag of the line being refilled
//   cache_valid_o             pulse: mark line valid with cache_tag_o
//   crit_valid_o/crit_data_o  pulse + data: critical word for IF/ID
//   stall_o                   high whenever the sequencer is not idle
module icache_refill_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int LINE_W  = 16,
  parameter int TAG_W   = 4,
  parameter int MEM_LAT = 1,
  localparam int OFF_W  = $clog2(LINE_W)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              EN,
  input  logic              load_ctrl_i,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] miss_addr_i,
  input  logic              flush_i,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cache_inval_o,
  output logic              cache_we_n_o,
  output logic [OFF_W-1:0]  cache_offset_o,
  output logic [TAG_W-1:0]  cache_tag_o,
  output logic [DATA_W-1:0] cache_wdata_o,
  output logic              cache_valid_o,
  output logic              crit_valid_o,
  output logic [DATA_W-1:0] crit_data_o,
  output logic              stall_o
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(4 * LINE_W - 1);
  localparam logic [OFF_W:0]    LINE_CNT  = (OFF_W + 1)'(LINE_W);
  localparam logic [OFF_W:0]    LAST_RET  = (OFF_W + 1)'(LINE_W - 1);
  localparam logic [OFF_W:0]    CNT_ONE   = (OFF_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [ADDR_W-1:0]  r_base;
  logic [OFF_W-1:0]   r_crit;
  logic [TAG_W-1:0]   r_tag;
  logic [OFF_W:0]     r_issue_cnt;
  logic [OFF_W:0]     r_ret_cnt;
  logic               r_first;
  logic [MEM_LAT-1:0] r_pipe_v;
  logic [OFF_W-1:0]   r_pipe_off [MEM_LAT];

  logic               w_start;
  logic               w_fill_live;
  logic               w_issue;
  logic               w_ret;
  logic [OFF_W-1:0]   w_issue_off;

  assign w_start     = (r_state == S_IDLE) & miss_i & ~flush_i & ~load_ctrl_i;
  // A flush or loader takeover kills issues and writes in that very cycle.
  assign w_fill_live = (r_state == S_FILL) & ~flush_i & ~load_ctrl_i;
  assign w_issue     = w_fill_live & EN & (r_issue_cnt < LINE_CNT);
  assign w_ret       = w_fill_live & r_pipe_v[MEM_LAT-1];
  // Wrap within the line by natural OFF_W-bit overflow.
  assign w_issue_off = r_crit + r_issue_cnt[OFF_W-1:0];
  assign stall_o     = (r_state != S_IDLE);
  assign cache_tag_o = r_tag;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_base      <= '0;
      r_crit      <= '0;
      r_tag       <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_first     <= 1'b0;
      r_pipe_v    <= '0;
      for (int i = 0; i < MEM_LAT; i++) r_pipe_off[i] <= '0;
    end else begin
      if (load_ctrl_i) begin
        r_pipe_v <= '0;
        r_first  <= 1'b0;
      end else begin
        r_pipe_v[0] <= w_issue;
        for (int i = 1; i < MEM_LAT; i++) r_pipe_v[i] <= r_pipe_v[i-1];
        r_first <= w_start;
      end
      // Offsets travel alongside the valid bits; only valid slots are consumed.
      r_pipe_off[0] <= w_issue_off;
      for (int i = 1; i < MEM_LAT; i++) r_pipe_off[i] <= r_pipe_off[i-1];
      if (w_start) begin
        r_base      <= miss_addr_i & ~LINE_MASK;
        r_crit      <= miss_addr_i[2 +: OFF_W];
        r_tag       <= miss_addr_i[2 + OFF_W +: TAG_W];
        r_issue_cnt <= '0;
        r_ret_cnt   <= '0;
      end
      if (w_issue) r_issue_cnt <= r_issue_cnt + CNT_ONE;
      if (w_ret)   r_ret_cnt   <= r_ret_cnt + CNT_ONE;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    mem_en_o       = 1'b0;
    mem_addr_o     = '0;
    cache_inval_o  = 1'b0;
    cache_we_n_o   = 1'b1;
    cache_offset_o = '0;
    cache_wdata_o  = '0;
    cache_valid_o  = 1'b0;
    crit_valid_o   = 1'b0;
    crit_data_o    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next_state = S_FILL;
      end
      S_FILL: begin
        cache_inval_o = r_first & ~load_ctrl_i;
        if (w_issue) begin
          mem_en_o   = 1'b1;
          mem_addr_o = r_base | ADDR_W'({w_issue_off, 2'b00});
        end
        if (w_ret) begin
          cache_we_n_o   = 1'b0;
          cache_offset_o = r_pipe_off[MEM_LAT-1];
          cache_wdata_o  = mem_rdata_i;
          // Issue order starts at the critical word, so the first return is it.
          if (r_ret_cnt == '0) begin
            crit_valid_o = 1'b1;
            crit_data_o  = mem_rdata_i;
          end
        end
        if (load_ctrl_i) begin
          w_next_state = S_IDLE;
        end else if (flush_i) begin
          w_next_state = S_DRAIN;
        end else if (w_ret && (r_ret_cnt == LAST_RET)) begin
          w_next_state = S_DONE;
        end
      end
      S_DRAIN: begin
        if (load_ctrl_i || (r_pipe_v == '0)) w_next_state = S_IDLE;
      end
      S_DONE: begin
        cache_valid_o = ~load_ctrl_i;
        w_next_state  = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

  logic        CLK;
  logic        RSTn;
  logic        EN;
  logic        load_ctrl_i;
  logic        miss_i;
  logic [19:0] miss_addr_i;
  logic        flush_i;
  logic        mem_en_o;
  logic [19:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        cache_inval_o;
  logic        cache_we_n_o;
  logic [3:0]  cache_offset_o;
  logic [3:0]  cache_tag_o;
  logic [31:0] cache_wdata_o;
  logic        cache_valid_o;
  logic        crit_valid_o;
  logic [31:0] crit_data_o;
  logic        stall_o;

  int checks;
  int failures;

  icache_refill_ctrl dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .load_ctrl_i(load_ctrl_i), .miss_i(miss_i),
    .miss_addr_i(miss_addr_i), .flush_i(flush_i), .mem_en_o(mem_en_o),
    .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i), .cache_inval_o(cache_inval_o),
    .cache_we_n_o(cache_we_n_o), .cache_offset_o(cache_offset_o), .cache_tag_o(cache_tag_o),
    .cache_wdata_o(cache_wdata_o), .cache_valid_o(cache_valid_o),
    .crit_valid_o(crit_valid_o), .crit_data_o(crit_data_o), .stall_o(stall_o)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [19:0] a);
    return {12'hC0D, a};
  endfunction

  // One-cycle-latency instruction memory.
  always @(posedge CLK) begin
    if (mem_en_o) mem_rdata_i <= mem_word(mem_addr_o);
  end

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({stall_o, mem_en_o, cache_inval_o, cache_valid_o, crit_valid_o, cache_we_n_o} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=000001",
               {stall_o, mem_en_o, cache_inval_o, cache_valid_o, crit_valid_o, cache_we_n_o});
    end
    checks++;
    if ({mem_addr_o, cache_tag_o, cache_offset_o} !== 28'h0) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=0", {mem_addr_o, cache_tag_o, cache_offset_o});
    end
    checks++;
    if ({cache_wdata_o, crit_data_o} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {cache_wdata_o, crit_data_o});
    end
    @(posedge CLK); #1;
    RSTn = 1'b1;
  endtask

  // Full refill with an optional EN-low window at cycles gap_k..gap_k+gap_len-1
  // (cycle 1 is the first FILL cycle).
  task automatic test_refill_seq(input string name, input logic [19:0] addr,
                                 input int gap_k, input int gap_len,
                                 input int exp_done, input logic [3:0] exp_tag);
    logic [19:0] base;
    logic [19:0] exp_addr;
    int crit, issued, rets, done_k, prev_off, cval_k;
    bit prev_iss, exp_en, exp_crit, exp_stall, exp_cval;
    base   = addr & ~20'h3F;
    crit   = int'((addr >> 2) & 20'hF);
    issued = 0; rets = 0; done_k = 0; prev_off = 0; cval_k = 0; prev_iss = 0;
    @(posedge CLK); #1;
    EN = 1'b1; miss_i = 1'b1; miss_addr_i = addr;
    @(posedge CLK); #1;
    miss_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin @(posedge CLK); #1; end
      EN = !(k >= gap_k && k < gap_k + gap_len);
      @(negedge CLK);
      exp_en    = (issued < 16) && EN;
      exp_addr  = base + 20'(4 * ((crit + issued) % 16));
      exp_crit  = prev_iss && (rets == 0);
      exp_cval  = (done_k != 0) && (k == done_k);
      exp_stall = (done_k == 0) || (k <= done_k);
      if (cache_valid_o === 1'b1) cval_k = k;
      checks++;
      if (mem_en_o !== exp_en) begin
        failures++;
        $display("FAIL %s k=%0d mem_en got=%0b exp=%0b", name, k, mem_en_o, exp_en);
      end
      if (exp_en) begin
        checks++;
        if (mem_addr_o !== exp_addr) begin
          failures++;
          $display("FAIL %s k=%0d mem_addr got=%h exp=%h", name, k, mem_addr_o, exp_addr);
        end
      end
      checks++;
      if (cache_we_n_o !== !prev_iss) begin
        failures++;
        $display("FAIL %s k=%0d we_n got=%0b exp=%0b", name, k, cache_we_n_o, !prev_iss);
      end
      if (prev_iss) begin
        checks++;
        if ({cache_offset_o, cache_wdata_o} !== {4'(prev_off), mem_word(base + 20'(4 * prev_off))}) begin
          failures++;
          $display("FAIL %s k=%0d write got=%h/%h exp=%h/%h", name, k, cache_offset_o,
                   cache_wdata_o, 4'(prev_off), mem_word(base + 20'(4 * prev_off)));
        end
      end
      checks++;
      if (crit_valid_o !== exp_crit) begin
        failures++;
        $display("FAIL %s k=%0d crit_valid got=%0b exp=%0b", name, k, crit_valid_o, exp_crit);
      end
      if (exp_crit) begin
        checks++;
        if (crit_data_o !== mem_word(addr & ~20'h3)) begin
          failures++;
          $display("FAIL %s k=%0d crit_data got=%h exp=%h", name, k, crit_data_o, mem_word(addr & ~20'h3));
        end
      end
      checks++;
      if ({stall_o, cache_valid_o, cache_inval_o} !== {exp_stall, exp_cval, (k == 1)}) begin
        failures++;
        $display("FAIL %s k=%0d stall/valid/inval got=%b exp=%b", name, k,
                 {stall_o, cache_valid_o, cache_inval_o}, {exp_stall, exp_cval, (k == 1)});
      end
      if (k == 1) begin
        checks++;
        if (cache_tag_o !== exp_tag) begin
          failures++;
          $display("FAIL %s tag got=%h exp=%h", name, cache_tag_o, exp_tag);
        end
      end
      if (prev_iss) begin
        rets++;
        if (rets == 16) done_k = k + 1;
      end
      prev_iss = exp_en;
      prev_off = (crit + issued) % 16;
      if (exp_en) issued++;
      if (done_k != 0 && k > done_k) break;
    end
    checks++;
    if (cval_k != exp_done) begin
      failures++;
      $display("FAIL %s cache_valid_cycle got=%0d exp=%0d", name, cval_k, exp_done);
    end
    EN = 1'b1;
  endtask

  task automatic test_flush();
    bit exp_en, exp_we_n;
    @(posedge CLK); #1;
    miss_i = 1'b1; miss_addr_i = 20'h00200;
    @(posedge CLK); #1;
    miss_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin @(posedge CLK); #1; end
      flush_i = (k == 5);
      @(negedge CLK);
      exp_en   = (k <= 4);
      exp_we_n = !(k >= 2 && k <= 4);
      checks++;
      if ({mem_en_o, cache_we_n_o, cache_valid_o, stall_o} !== {exp_en, exp_we_n, 1'b0, (k <= 6)}) begin
        failures++;
        $display("FAIL flush k=%0d en/we_n/valid/stall got=%b exp=%b", k,
                 {mem_en_o, cache_we_n_o, cache_valid_o, stall_o}, {exp_en, exp_we_n, 1'b0, (k <= 6)});
      end
      if (k == 4) begin
        checks++;
        if ({mem_addr_o, cache_offset_o} !== {20'h0020C, 4'd2}) begin
          failures++;
          $display("FAIL flush k=4 addr/off got=%h/%h exp=0020c/2", mem_addr_o, cache_offset_o);
        end
      end
      if (k == 5) begin
        checks++;
        if (crit_valid_o !== 1'b0) begin
          failures++;
          $display("FAIL flush k=5 crit_valid got=%0b exp=0", crit_valid_o);
        end
      end
    end
    flush_i = 1'b0;
  endtask

  task automatic test_load_abort();
    @(posedge CLK); #1;
    miss_i = 1'b1; miss_addr_i = 20'h00048;
    @(posedge CLK); #1;
    miss_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(posedge CLK); #1; end
      load_ctrl_i = (k == 4);
      @(negedge CLK);
      checks++;
      if ({mem_en_o, cache_we_n_o, stall_o, cache_valid_o, cache_inval_o} !==
          {(k <= 3), !(k == 2 || k == 3), (k <= 4), 1'b0, (k == 1)}) begin
        failures++;
        $display("FAIL load_abort k=%0d en/we_n/stall/valid/inval got=%b exp=%b", k,
                 {mem_en_o, cache_we_n_o, stall_o, cache_valid_o, cache_inval_o},
                 {(k <= 3), !(k == 2 || k == 3), (k <= 4), 1'b0, (k == 1)});
      end
    end
    load_ctrl_i = 1'b0;
    test_refill_seq("t5_refill", 20'h00100, 0, 0, 18, 4'h4);
  endtask

  task automatic test_miss_flush_same();
    @(posedge CLK); #1;
    miss_i = 1'b1; flush_i = 1'b1; miss_addr_i = 20'h00048;
    @(posedge CLK); #1;
    miss_i = 1'b0; flush_i = 1'b0;
    @(negedge CLK);
    checks++;
    if ({stall_o, mem_en_o, cache_inval_o} !== 3'b000) begin
      failures++;
      $display("FAIL miss_flush stall/en/inval got=%b exp=000", {stall_o, mem_en_o, cache_inval_o});
    end
  endtask

  task automatic test_reset_mid_fill();
    @(posedge CLK); #1;
    miss_i = 1'b1; miss_addr_i = 20'h00048;
    @(posedge CLK); #1;
    miss_i = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({stall_o, mem_en_o, cache_tag_o} !== {1'b1, 1'b1, 4'h1}) begin
      failures++;
      $display("FAIL rst_mid pre got=%b exp=111/1", {stall_o, mem_en_o, cache_tag_o});
    end
    @(posedge CLK); #1;
    RSTn = 1'b0;
    #1;
    checks++;
    if ({stall_o, mem_en_o, cache_we_n_o, cache_tag_o, mem_addr_o} !== {1'b0, 1'b0, 1'b1, 4'h0, 20'h0}) begin
      failures++;
      $display("FAIL rst_mid async got=%h exp=%h", {stall_o, mem_en_o, cache_we_n_o, cache_tag_o, mem_addr_o},
               {1'b0, 1'b0, 1'b1, 4'h0, 20'h0});
    end
    @(posedge CLK); #1;
    RSTn = 1'b1;
    @(negedge CLK);
    checks++;
    if ({stall_o, mem_en_o} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid after got=%b exp=00", {stall_o, mem_en_o});
    end
  endtask

  initial begin
    CLK = 1'b0; RSTn = 1'b0; EN = 1'b1; load_ctrl_i = 1'b0; miss_i = 1'b0;
    flush_i = 1'b0; miss_addr_i = '0;
    checks = 0; failures = 0;
    test_reset();
    test_refill_seq("t1_crit2", 20'h00048, 0, 0, 18, 4'h1);
    test_refill_seq("t2_wrap15", 20'h0007C, 0, 0, 18, 4'h1);
    test_flush();
    test_refill_seq("t4_en_gap", 20'h003C4, 5, 3, 21, 4'hF);
    test_load_abort();
    test_miss_flush_same();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
